seg_mux_driver: RTL and testbench

- Parametrised N-digit, time-multiplexed driver for common-anode seven-segment displays.
- Drives one shared active-low segment bus plus per-digit active-low anode enables.
- Display data is double-buffered; new values take effect only at frame boundaries (no tearing).
- Also provides a prescaled blink output for a status LED; sits between switch/datapath logic and the board display pins.

---
 rtl/seg_mux_driver.sv | 215 +++++++++++++++++++++
 tb/tb_seg_mux_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - time-multiplexed N-digit common-anode seven-segment driver
//
// Scans NUM_DIGITS digits over one shared active-low segment bus. Each digit
// owns a slot of 2^REFRESH_DIV_W cycles. The first DEAD_CYCLES cycles of every
// slot are blanked so the previous digit's pattern never ghosts onto the next
// anode. Display data is double-buffered: load writes a shadow copy, and the
// shadow is promoted to the active copy only at the end of a full frame. This
// means a frame never mixes old and new digits.
//
// Optional feature (macro SEG_MUX_BLINK_MASK_EN): adds input blink_mask. Its
// bits are buffered alongside digit_en. An enabled digit whose mask bit is set
// is blanked while the blink output is high.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   load        single-cycle strobe, captures digits/digit_en into the shadow buffer
//   digits      4*NUM_DIGITS, hex nibble per digit, digit i = digits[4i+3:4i]
//   digit_en    NUM_DIGITS, per-digit enable, 0 keeps the digit blank
//   blink_mask  NUM_DIGITS, per-digit blink enable (only with SEG_MUX_BLINK_MASK_EN)
//   seg         7, active-low segments {g,f,e,d,c,b,a}, registered
//   an          NUM_DIGITS, active-low anode enables, at most one low, registered
//   pending     shadow buffer holds data not yet committed
//   frame_done  one-cycle pulse in the cycle after the frame commit point
//   blink       MSB of the free-running blink counter

module seg_mux_driver #(
    parameter int NUM_DIGITS    = 2,
    parameter int REFRESH_DIV_W = 10,
    parameter int DEAD_CYCLES   = 4,
    parameter int BLINK_DIV_W   = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG_MUX_BLINK_MASK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done,
    output logic                    blink
);

    localparam int                       IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REFRESH_DIV_W-1:0] DEAD_CNT = REFRESH_DIV_W'(DEAD_CYCLES);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Timing state.
    logic [REFRESH_DIV_W-1:0] ref_cnt_q,   ref_cnt_d;
    logic [IDX_W-1:0]         idx_q,       idx_d;
    logic [BLINK_DIV_W-1:0]   blink_cnt_q, blink_cnt_d;

    // Double-buffered display data.
    logic [4*NUM_DIGITS-1:0]  act_dig_q,   act_dig_d;
    logic [NUM_DIGITS-1:0]    act_en_q,    act_en_d;
    logic [4*NUM_DIGITS-1:0]  shd_dig_q,   shd_dig_d;
    logic [NUM_DIGITS-1:0]    shd_en_q,    shd_en_d;
    logic                     pending_q,   pending_d;
`ifdef SEG_MUX_BLINK_MASK_EN
    logic [NUM_DIGITS-1:0]    act_mask_q,  act_mask_d;
    logic [NUM_DIGITS-1:0]    shd_mask_q,  shd_mask_d;
`endif

    // Registered pin drivers.
    logic [6:0]               seg_q,       seg_d;
    logic [NUM_DIGITS-1:0]    an_q,        an_d;
    logic                     frame_done_q, frame_done_d;

    // Scan decode of the current slot.
    logic                     tc;
    logic                     commit;
    logic [3:0]               cur_nib;
    logic                     cur_en;
    logic                     cur_blank;

    always_comb begin
        tc     = (ref_cnt_q == '1);
        commit = tc && (idx_q == LAST_IDX);

        ref_cnt_d   = ref_cnt_q + REFRESH_DIV_W'(1);
        blink_cnt_d = blink_cnt_q + BLINK_DIV_W'(1);

        idx_d = idx_q;
        if (tc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        // Commit is evaluated against the old shadow before load overwrites it.
        // A load landing on the commit cycle therefore promotes the previous
        // data and leaves the new data pending for the next frame.
        act_dig_d = act_dig_q;
        act_en_d  = act_en_q;
        shd_dig_d = shd_dig_q;
        shd_en_d  = shd_en_q;
        pending_d = pending_q;
`ifdef SEG_MUX_BLINK_MASK_EN
        act_mask_d = act_mask_q;
        shd_mask_d = shd_mask_q;
`endif
        if (commit && pending_q) begin
            act_dig_d = shd_dig_q;
            act_en_d  = shd_en_q;
`ifdef SEG_MUX_BLINK_MASK_EN
            act_mask_d = shd_mask_q;
`endif
            pending_d = 1'b0;
        end
        if (load) begin
            shd_dig_d = digits;
            shd_en_d  = digit_en;
`ifdef SEG_MUX_BLINK_MASK_EN
            shd_mask_d = blink_mask;
`endif
            pending_d = 1'b1;
        end

        // Select the active data for the digit under scan.
        cur_nib   = 4'h0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = act_dig_q[4*i +: 4];
                cur_en  = act_en_q[i];
`ifdef SEG_MUX_BLINK_MASK_EN
                cur_blank = act_mask_q[i] && blink_cnt_q[BLINK_DIV_W-1];
`endif
            end
        end

        // Default is fully blank, which covers the dead time, disabled
        // digits and blink-masked digits.
        seg_d = 7'h7F;
        an_d  = '1;
        if ((ref_cnt_q >= DEAD_CNT) && cur_en && !cur_blank) begin
            seg_d = hex_to_seg(cur_nib);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
        end

        frame_done_d = commit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt_q    <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            act_dig_q    <= '0;
            act_en_q     <= '0;
            shd_dig_q    <= '0;
            shd_en_q     <= '0;
            pending_q    <= 1'b0;
`ifdef SEG_MUX_BLINK_MASK_EN
            act_mask_q   <= '0;
            shd_mask_q   <= '0;
`endif
            seg_q        <= 7'h7F;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            ref_cnt_q    <= ref_cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            act_dig_q    <= act_dig_d;
            act_en_q     <= act_en_d;
            shd_dig_q    <= shd_dig_d;
            shd_en_q     <= shd_en_d;
            pending_q    <= pending_d;
`ifdef SEG_MUX_BLINK_MASK_EN
            act_mask_q   <= act_mask_d;
            shd_mask_q   <= shd_mask_d;
`endif
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign blink      = blink_cnt_q[BLINK_DIV_W-1];

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - self-checking bench for seg_mux_driver

module tb_seg_mux_driver;

    localparam int ND   = 2;
    localparam int RW   = 4;
    localparam int DEAD = 2;
    localparam int BW   = 6;
    localparam int SLOT = 1 << RW;
    localparam int BPER = 1 << BW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [4*ND-1:0] digits = '0;
    logic [ND-1:0]   digit_en = '0;
    logic [ND-1:0]   blink_mask = '0;
    logic [6:0]      seg;
    logic [ND-1:0]   an;
    logic            pending;
    logic            frame_done;
    logic            blink;

    seg_mux_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV_W(RW), .DEAD_CYCLES(DEAD), .BLINK_DIV_W(BW)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .digits(digits), .digit_en(digit_en),
`ifdef SEG_MUX_BLINK_MASK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg), .an(an), .pending(pending), .frame_done(frame_done), .blink(blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Segment patterns straight from the decode table, {g..a} active low.
    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: time since reset plus the two data buffers.
    int              t = 0;
    logic [4*ND-1:0] m_act_d = '0, m_shd_d = '0;
    logic [ND-1:0]   m_act_e = '0, m_shd_e = '0;
    logic [ND-1:0]   m_act_m = '0, m_shd_m = '0;
    bit              m_pend = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // One clock: model advance from the inputs now on the pins, then compare.
    task automatic step();
        int         pos, slot;
        logic [6:0] es;
        logic [ND-1:0] ea;
        bit         efd, commit, blink_now, mask_on;
        es  = 7'h7F;
        ea  = '1;
        efd = 0;
        if (reset) begin
            t = 0; m_act_d = '0; m_shd_d = '0; m_act_e = '0; m_shd_e = '0;
            m_act_m = '0; m_shd_m = '0; m_pend = 0;
        end else begin
            pos       = t % SLOT;
            slot      = (t / SLOT) % ND;
            blink_now = (t % BPER) >= BPER / 2;
`ifdef SEG_MUX_BLINK_MASK_EN
            mask_on = m_act_m[slot] && blink_now;
`else
            mask_on = 0;
`endif
            if (pos >= DEAD && m_act_e[slot] && !mask_on) begin
                es = dec_tab[m_act_d[slot*4 +: 4]];
                ea[slot] = 1'b0;
            end
            commit = (pos == SLOT - 1) && (slot == ND - 1);
            efd = commit;
            if (commit && m_pend) begin
                m_act_d = m_shd_d; m_act_e = m_shd_e; m_act_m = m_shd_m; m_pend = 0;
            end
            if (load) begin
                m_shd_d = digits; m_shd_e = digit_en;
`ifdef SEG_MUX_BLINK_MASK_EN
                m_shd_m = blink_mask;
`endif
                m_pend = 1;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check("seg", int'(seg), int'(es));
        check("an", int'(an), int'(ea));
        check("pending", int'(pending), int'(m_pend));
        check("frame_done", int'(frame_done), int'(efd));
        check("blink", int'(blink), int'((t % BPER) >= BPER / 2));
        check("an_single_low", int'($countones(~an) <= 1), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] dig;
        logic [1:0] en;
        logic [6:0] seg0;
        logic [1:0] an0;
        logic [6:0] seg1;
        logic [1:0] an1;
    } vec_t;

    vec_t vecs [5];
    int   fd_count, toggles;
    bit   seen_bad;
    logic prev_blink;

    initial begin
        vecs[0] = '{8'h3A, 2'b11, 7'b0001000, 2'b10, 7'b0110000, 2'b01};
        vecs[1] = '{8'h34, 2'b11, 7'b0011001, 2'b10, 7'b0110000, 2'b01};
        vecs[2] = '{8'h56, 2'b01, 7'b0000010, 2'b10, 7'h7F,      2'b11};
        vecs[3] = '{8'hF0, 2'b10, 7'h7F,      2'b11, 7'b0001110, 2'b01};
        vecs[4] = '{8'hB9, 2'b11, 7'b0010000, 2'b10, 7'b0000011, 2'b01};

        // Table: load at t=0, sample mid-slot in the second frame.
        foreach (vecs[k]) begin
            do_reset();
            check("reset_seg", int'(seg), 'h7F);
            check("reset_an", int'(an), 3);
            digits = vecs[k].dig; digit_en = vecs[k].en; load = 1'b1;
            step();
            load = 1'b0;
            while (t < 58) begin
                step();
                if (t == 20) check("tbl_pending_before", int'(pending), 1);
                if (t == 41) begin
                    check("tbl_seg0", int'(seg), int'(vecs[k].seg0));
                    check("tbl_an0", int'(an), int'(vecs[k].an0));
                end
                if (t == 57) begin
                    check("tbl_seg1", int'(seg), int'(vecs[k].seg1));
                    check("tbl_an1", int'(an), int'(vecs[k].an1));
                end
            end
        end

        // Back-to-back loads in one frame: last one wins, 1/2 never shown.
        do_reset();
        digit_en = 2'b11;
        fd_count = 0; seen_bad = 0;
        while (t < 96) begin
            load = (t == 5) || (t == 7);
            digits = (t == 5) ? 8'h12 : 8'h34;
            step();
            load = 1'b0;
            if (frame_done) fd_count++;
            if (seg == 7'b1111001 || seg == 7'b0100100) seen_bad = 1;
            if (t == 41) check("lastwins_seg0", int'(seg), 'b0011001);
        end
        check("lastwins_no_12", int'(seen_bad), 0);
        check("frame_done_count", fd_count, 3);

        // Load on the commit cycle: previous shadow shows first.
        do_reset();
        digits = 8'h34; digit_en = 2'b11; load = 1'b1;
        step();
        load = 1'b0;
        while (t < 31) step();
        digits = 8'h56; load = 1'b1;
        step();
        load = 1'b0;
        check("commit_load_pending", int'(pending), 1);
        while (t < 74) begin
            step();
            if (t == 41) check("commit_load_old", int'(seg), 'b0011001);
            if (t == 64) check("commit_load_pend_clr", int'(pending), 0);
            if (t == 73) check("commit_load_new", int'(seg), 'b0000010);
        end

        // Reset mid-frame with data pending: pending data is discarded.
        do_reset();
        digits = 8'h3A; digit_en = 2'b11; load = 1'b1;
        step();
        load = 1'b0;
        while (t < 40) begin
            load = (t == 35);
            digits = 8'h77;
            step();
            load = 1'b0;
        end
        check("pre_reset_pending", int'(pending), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_seg", int'(seg), 'h7F);
        check("midreset_an", int'(an), 3);
        check("midreset_pending", int'(pending), 0);
        check("midreset_blink", int'(blink), 0);
        seen_bad = 0;
        toggles = 0;
        prev_blink = blink;
        while (t < 128) begin
            step();
            if (seg == 7'b1111000) seen_bad = 1;
            if (blink != prev_blink) toggles++;
            prev_blink = blink;
        end
        check("old_shadow_never_shown", int'(seen_bad), 0);
        check("blink_toggles", toggles, 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 399) == 0);
            load       = ($urandom_range(0, 5) == 0);
            digits     = 8'($urandom);
            digit_en   = 2'($urandom);
            blink_mask = 2'($urandom);
            step();
        end
        reset = 1'b0; load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
